bias_buf_pingpong: RTL

//  Parametrised double-buffered bias store for the conv/FC engine. Streams LANES bias

---
 rtl/bias_buf_pingpong.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bias_buf_pingpong.sv
// Double-buffered bias store: shadow bank loads while the active bank is read.
// Optional macro BIAS_BUF_RD_CHECK_EN enables sticky rd_err and zeroed bad reads.
module bias_buf_pingpong #(
  parameter  int DATA_W = 16,
  parameter  int LANES  = 4,
  parameter  int DEPTH  = 64,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_start,
  input  logic                    wr_valid,
  input  logic [LANES*DATA_W-1:0] wr_data,
  output logic                    wr_ready,
  output logic                    load_done,
  input  logic                    swap,
  output logic                    bank_sel,
  output logic                    active_valid,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  output logic                    rd_err
);

  localparam int BEATS = DEPTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(2 * DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              bank_q, bank_d;
  logic              av_q, av_d;
  logic              we;
  logic              oor;
  logic              bad;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] mem [2*DEPTH];

  // Load FSM, beat counter and bank pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bank_q  <= 1'b0;
      av_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      av_q    <= av_d;
    end
  end

  // Next-state: restart wins over a beat; swap is taken only when full
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    av_d    = av_q;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (load_start) begin
          cnt_d = '0;
        end else if (wr_valid) begin
          we = 1'b1;
          if (cnt_q == CW'(BEATS - 1)) begin
            state_d = S_FULL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_FULL: begin
        if (swap) begin
          bank_d  = ~bank_q;
          av_d    = 1'b1;
          state_d = S_IDLE;
        end
        if (load_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign wr_ready     = (state_q == S_LOAD);
  assign load_done    = (state_q == S_FULL);
  assign bank_sel     = bank_q;
  assign active_valid = av_q;

  // Beat write into the shadow bank, one entry per lane
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int k = 0; k < LANES; k++) begin
        mem[AW'((bank_q ? 0 : DEPTH) + int'(cnt_q) * LANES + k)]
          <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign oor     = ({1'b0, rd_index} >= (IDX_W+1)'(DEPTH));
  assign rd_addr = AW'((bank_q ? DEPTH : 0) + int'(rd_index));

`ifdef BIAS_BUF_RD_CHECK_EN
  assign bad = oor | ~av_q;

  // Sticky error on any out-of-range or premature read
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_err <= 1'b0;
    end else if (rd_en && bad) begin
      rd_err <= 1'b1;
    end
  end
`else
  assign bad    = oor;
  assign rd_err = 1'b0;
`endif

  // Registered read from the pre-swap active bank
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= bad ? '0 : mem[rd_addr];
      end
    end
  end

endmodule
